// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer_if
//  Description : Request/status bundle between the reset sequencer and the
//                board-side logic (raw requests in, domain resets and the
//                latched reset cause out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if #(
    parameter int NUM_SRC     = 2,
    parameter int NUM_DOMAINS = 3
);
    logic [NUM_SRC-1:0]     req_in;
    logic                   cause_clr;
    logic [NUM_DOMAINS-1:0] rst_out;
    logic                   busy;
    logic [NUM_SRC:0]       cause;

    // Board / SoC side: raises requests, consumes resets and cause flags
    modport master (
        output req_in,
        output cause_clr,
        input  rst_out,
        input  busy,
        input  cause
    );

    // Sequencer side
    modport slave (
        input  req_in,
        input  cause_clr,
        output rst_out,
        output busy,
        output cause
    );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Synchronises (and optionally debounces) several external
//                reset requests, stretches the resulting reset and releases
//                NUM_DOMAINS domain resets in staggered order. Latches the
//                cause of the last reset.
//                Optional feature macro: RESET_SEQ_DEBOUNCE_EN
//                  defined   -> per-source debounce filter
//                  undefined -> filtered value = synchroniser output
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int                 NUM_SRC         = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MODE       = 2'b10,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 16,
    parameter int                 STRETCH_CYCLES  = 255,
    parameter int                 NUM_DOMAINS     = 3,
    parameter int                 STAGGER_CYCLES  = 4
) (
    input  wire                 clk,
    input  wire                 reset,
    reset_sequencer_if.slave    bus
);

    localparam int STRETCH_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int STAGGER_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam logic [STRETCH_W-1:0] C_STRETCH_LAST = STRETCH_W'(STRETCH_CYCLES - 1);
    localparam logic [STAGGER_W-1:0] C_STAGGER_LAST = STAGGER_W'(STAGGER_CYCLES - 1);
    localparam logic [NUM_SRC:0]     C_CAUSE_POR    = {1'b1, {NUM_SRC{1'b0}}};

    // Elaboration-time guards on parameter minimums
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("reset_sequencer: DEBOUNCE_CYCLES must be >= 1");
    end
    if (STRETCH_CYCLES < 1) begin : g_chk_stretch
        $error("reset_sequencer: STRETCH_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_chk_stagger
        $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NUM_SRC-1:0]                  sync_out;
    logic [NUM_SRC-1:0]                  filt;

    // Shift each raw request into its synchroniser chain
    always_comb begin
        sync_d = sync_q;
        for (int s = 0; s < NUM_SRC; s++) begin
            sync_d[s]   = {sync_q[s][SYNC_STAGES-2:0], bus.req_in[s]};
            sync_out[s] = sync_q[s][SYNC_STAGES-1];
        end
    end

    // Synchroniser flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef RESET_SEQ_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Debounce: the filtered value follows the synchronised value only
    // after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] C_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SRC-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [NUM_SRC-1:0]           filt_q, filt_d;

    // Count mismatch cycles; adopt the new value at the terminal count
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = db_cnt_q;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (sync_out[s] != filt_q[s]) begin
                if (db_cnt_q[s] == C_DB_LAST) begin
                    filt_d[s]   = sync_out[s];
                    db_cnt_d[s] = '0;
                end else begin
                    db_cnt_d[s] = db_cnt_q[s] + DB_W'(1);
                end
            end else begin
                db_cnt_d[s] = '0;
            end
        end
    end

    // Debounce state flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_out;
`endif

    // ------------------------------------------------------------------
    // Trigger generation
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] filt_dly_q, filt_dly_d;
    logic [NUM_SRC-1:0] trig;
    logic               any_trig;

    // Level sources trigger on the filtered value, edge sources on its fall
    always_comb begin
        filt_dly_d = filt;
        for (int s = 0; s < NUM_SRC; s++) begin
            trig[s] = EDGE_MODE[s] ? (~filt[s] & filt_dly_q[s]) : filt[s];
        end
        any_trig = |trig;
    end

    // One-cycle delayed copy of the filtered value for fall detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_dly_q <= '0;
        end else begin
            filt_dly_q <= filt_dly_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [STRETCH_W-1:0]   stretch_cnt_q, stretch_cnt_d;
    logic [STAGGER_W-1:0]   stagger_cnt_q, stagger_cnt_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic [NUM_DOMAINS-1:0] rst_shift;
    logic                   busy_q, busy_d;
    logic [NUM_SRC:0]       cause_q, cause_d;

    // Next state, counters, staggered release and cause latching
    always_comb begin
        state_d       = state_q;
        stretch_cnt_d = stretch_cnt_q;
        stagger_cnt_d = stagger_cnt_q;
        rst_out_d     = rst_out_q;
        busy_d        = busy_q;
        // Domains release lowest-first, so each step shifts one more zero in
        rst_shift     = rst_out_q << 1;

        case (state_q)
            ST_ASSERT: begin
                rst_out_d     = '1;
                busy_d        = 1'b1;
                stagger_cnt_d = '0;
                if (any_trig) begin
                    stretch_cnt_d = '0;
                end else if (stretch_cnt_q == C_STRETCH_LAST) begin
                    stretch_cnt_d = '0;
                    rst_out_d     = rst_shift;
                    if (rst_shift == '0) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    stretch_cnt_d = stretch_cnt_q + STRETCH_W'(1);
                end
            end

            ST_RELEASE: begin
                if (any_trig) begin
                    state_d       = ST_ASSERT;
                    rst_out_d     = '1;
                    busy_d        = 1'b1;
                    stretch_cnt_d = '0;
                    stagger_cnt_d = '0;
                end else if (stagger_cnt_q == C_STAGGER_LAST) begin
                    stagger_cnt_d = '0;
                    rst_out_d     = rst_shift;
                    if (rst_shift == '0) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end
                end else begin
                    stagger_cnt_d = stagger_cnt_q + STAGGER_W'(1);
                end
            end

            ST_RUN: begin
                rst_out_d = '0;
                busy_d    = 1'b0;
                if (any_trig) begin
                    state_d       = ST_ASSERT;
                    rst_out_d     = '1;
                    busy_d        = 1'b1;
                    stretch_cnt_d = '0;
                    stagger_cnt_d = '0;
                end
            end

            default: begin
                state_d       = ST_ASSERT;
                rst_out_d     = '1;
                busy_d        = 1'b1;
                stretch_cnt_d = '0;
                stagger_cnt_d = '0;
            end
        endcase

        // Setting a cause bit wins over a simultaneous clear
        cause_d = {1'b0, trig} | (bus.cause_clr ? '0 : cause_q);
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ASSERT;
            stretch_cnt_q <= '0;
            stagger_cnt_q <= '0;
            rst_out_q     <= '1;
            busy_q        <= 1'b1;
            cause_q       <= C_CAUSE_POR;
        end else begin
            state_q       <= state_d;
            stretch_cnt_q <= stretch_cnt_d;
            stagger_cnt_q <= stagger_cnt_d;
            rst_out_q     <= rst_out_d;
            busy_q        <= busy_d;
            cause_q       <= cause_d;
        end
    end

    assign bus.rst_out = rst_out_q;
    assign bus.busy    = busy_q;
    assign bus.cause   = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Self-checking bench for reset_sequencer. A closed-form model
//                (time since last registered trigger, window-based debounce)
//                predicts every output each cycle; directed scenarios pin
//                absolute latencies; a randomized phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int NUM_SRC     = 2;
    localparam int NUM_DOMAINS = 3;
    localparam int SYNC        = 2;
    localparam int STRETCH     = 255;
    localparam int STAG        = 4;
    localparam logic [NUM_SRC-1:0] EDGE = 2'b10;
`ifdef RESET_SEQ_DEBOUNCE_EN
    localparam int DEB = 16;
`else
    localparam int DEB = 0;
`endif
    localparam int LAT = SYNC + DEB + 1;
    localparam int HD  = SYNC + DEB + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    reset_sequencer_if #(.NUM_SRC(NUM_SRC), .NUM_DOMAINS(NUM_DOMAINS)) bus ();

    reset_sequencer #(
        .NUM_SRC        (NUM_SRC),
        .EDGE_MODE      (EDGE),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(16),
        .STRETCH_CYCLES (STRETCH),
        .NUM_DOMAINS    (NUM_DOMAINS),
        .STAGGER_CYCLES (STAG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                 hr [NUM_SRC][HD];   // raw request samples, [0] = newest
    bit [NUM_SRC-1:0]   filt_m;
    bit [NUM_SRC-1:0]   pend_m;             // trigger to be registered next edge
    bit [NUM_SRC:0]     cause_m;
    int                 e_m;                // edges since reset release
    int                 l_m;                // edge of last registered trigger

    task automatic model_init();
        for (int s = 0; s < NUM_SRC; s++)
            for (int k = 0; k < HD; k++) hr[s][k] = 1'b0;
        filt_m  = '0;
        pend_m  = '0;
        cause_m = {1'b1, {NUM_SRC{1'b0}}};
        e_m     = 0;
        l_m     = 0;
    endtask

    task automatic model_step();
        bit prevf;
        bit flip;
        e_m++;
        if (pend_m != '0) l_m = e_m;
        if (bus.cause_clr) cause_m = {1'b0, pend_m};
        else               cause_m = cause_m | {1'b0, pend_m};
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = HD - 1; k > 0; k--) hr[s][k] = hr[s][k-1];
            hr[s][0] = bus.req_in[s];
            prevf = filt_m[s];
            if (DEB == 0) begin
                filt_m[s] = hr[s][SYNC-1];
            end else begin
                // flip once the synchronised value disagreed for DEB cycles in a row
                flip = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (hr[s][SYNC-1+j] == filt_m[s]) flip = 1'b0;
                if (flip) filt_m[s] = ~filt_m[s];
            end
            pend_m[s] = EDGE[s] ? (~filt_m[s] & prevf) : filt_m[s];
        end
    endtask

    function automatic logic [NUM_DOMAINS-1:0] exp_rst();
        logic [NUM_DOMAINS-1:0] r;
        for (int i = 0; i < NUM_DOMAINS; i++)
            r[i] = ((e_m - l_m) < (STRETCH + i * STAG));
        return r;
    endfunction

    initial begin
        model_init();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_init();
            else       model_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic [NUM_DOMAINS-1:0] er;
        forever begin
            @(negedge clk);
            #1;
            er = exp_rst();
            chk("model_rst_out", 32'(bus.rst_out), 32'(er));
            chk("model_busy",    32'(bus.busy),    32'(er[NUM_DOMAINS-1]));
            chk("model_cause",   32'(bus.cause),   32'(cause_m));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(negedge clk);
        #2;
    endtask

    // idx < 0 waits on busy, otherwise on rst_out[idx]; returns edge count
    task automatic wait_for(input int idx, input logic val, input int budget,
                            input string name, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            if ((idx < 0) ? (bus.busy == val) : (bus.rst_out[idx] == val)) begin
                at = cyc;
                break;
            end
            nxt();
        end
        if (at < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int t0, at, gseen, x;
        bus.req_in    = '0;
        bus.cause_clr = 1'b0;
        #1 reset = 1'b1;
        repeat (5) nxt();
        chk("reset_rst_out", 32'(bus.rst_out), 32'h7);
        chk("reset_busy",    32'(bus.busy),    32'h1);
        chk("reset_cause",   32'(bus.cause),   32'h4);

        // Power-on release
        reset = 1'b0;
        t0 = cyc;
        wait_for(0, 1'b0, 300, "por_rst0", at); chk("por_rst0_edge", at - t0, 255);
        wait_for(1, 1'b0, 20,  "por_rst1", at); chk("por_rst1_edge", at - t0, 259);
        wait_for(2, 1'b0, 20,  "por_rst2", at); chk("por_rst2_edge", at - t0, 263);
        chk("por_busy",  32'(bus.busy),  32'h0);
        chk("por_cause", 32'(bus.cause), 32'h4);

        // Level source 0, held 40 cycles
        nxt();
        bus.req_in[0] = 1'b1;
        t0 = cyc;
        wait_for(0, 1'b1, 60, "lvl_rise", at);
        chk("lvl_latency",  at - t0, LAT);
        chk("lvl_all_high", 32'(bus.rst_out), 32'h7);
        chk("lvl_cause",    32'(bus.cause),   32'h5);
        while (cyc < t0 + 40) nxt();
        bus.req_in[0] = 1'b0;
        t0 = cyc;
        wait_for(0, 1'b0, 400, "lvl_release", at);
        chk("lvl_release_edge", at - t0, LAT - 1 + STRETCH);
        wait_for(-1, 1'b0, 20, "lvl_run", at);

        // Short pulse on source 0
        nxt();
        bus.req_in[0] = 1'b1;
        repeat (10) nxt();
        bus.req_in[0] = 1'b0;
        gseen = 0;
        repeat (40) begin
            nxt();
            if (bus.busy) gseen = 1;
        end
        chk("glitch_reset", gseen, (10 >= DEB) ? 1 : 0);
        chk("glitch_cause", 32'(bus.cause), 32'h5);
        wait_for(-1, 1'b0, 400, "glitch_run", at);

        // Edge source 1: rise ignored, fall triggers
        nxt();
        bus.req_in[1] = 1'b1;
        gseen = 0;
        repeat (30) begin
            nxt();
            if (bus.busy) gseen = 1;
        end
        chk("edge_rise_ignored", gseen, 0);
        bus.req_in[1] = 1'b0;
        t0 = cyc;
        wait_for(0, 1'b1, 60, "edge_fall", at);
        chk("edge_latency", at - t0, LAT);
        chk("edge_cause",   32'(bus.cause), 32'h7);

        // Retrigger registered between rst_out[0] and rst_out[1] releases
        x = at + STRETCH;
        repeat (5) nxt();
        bus.req_in[1] = 1'b1;
        while (cyc < x + 2 - LAT) nxt();
        bus.req_in[1] = 1'b0;
        wait_for(0, 1'b0, 400, "rt_rst0_fall", at);
        chk("rt_rst0_fall_edge", at, x);
        wait_for(0, 1'b1, 10, "rt_rst0_rise", at);
        chk("rt_rst0_rise_edge", at, x + 2);
        chk("rt_all_high", 32'(bus.rst_out), 32'h7);
        t0 = at;
        wait_for(0, 1'b0, 400, "rt_restretch", at);
        chk("rt_restretch_len", at - t0, STRETCH);

        // Asynchronous reset in mid-RELEASE
        nxt();
        reset = 1'b1;
        #1;
        chk("midrel_rst_out", 32'(bus.rst_out), 32'h7);
        chk("midrel_busy",    32'(bus.busy),    32'h1);
        chk("midrel_cause",   32'(bus.cause),   32'h4);
        repeat (3) nxt();
        reset = 1'b0;

        // Clear versus set in the same cycle
        nxt();
        bus.req_in[1] = 1'b1;
        repeat (30) nxt();
        bus.req_in[1] = 1'b0;
        for (int n = 0; n < 60 && !bus.cause[1]; n++) nxt();
        chk("cs_cause_before", 32'(bus.cause), 32'h6);
        bus.req_in[0] = 1'b1;
        t0 = cyc;
        while (cyc < t0 + LAT - 1) nxt();
        bus.cause_clr = 1'b1;
        nxt();
        chk("cs_cause_after", 32'(bus.cause), 32'h1);
        bus.cause_clr = 1'b0;
        bus.req_in[0] = 1'b0;
        wait_for(-1, 1'b0, 700, "cs_run", at);

        // Randomized phase
        for (int it = 0; it < 120; it++) begin
            int s;
            int len;
            s   = $urandom_range(0, NUM_SRC - 1);
            len = $urandom_range(1, 40);
            bus.req_in[s] = ~bus.req_in[s];
            repeat (len) begin
                bus.cause_clr = ($urandom_range(0, 15) == 0);
                nxt();
            end
            bus.cause_clr = 1'b0;
            if ($urandom_range(0, 30) == 0) begin
                reset = 1'b1;
                nxt();
                reset = 1'b0;
            end
            if ((it % 40) == 39) begin
                bus.req_in = '0;
                repeat (300) nxt();
            end
        end
        bus.req_in = '0;
        repeat (20) nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset controller for the Murax-based toplevels, generalising the PLL-lock reset counter and the GRESET falling-edge synchroniser. It synchronises and debounces several external reset requests (each level- or falling-edge-triggered), stretches the resulting reset, and releases it to several clock-domain consumers in a staggered order. It also latches the cause of the last reset. It sits between the board pins / PLL lock and the `io_asyncReset` inputs of the SoC and its peripherals.

## Interface
- `NUM_SRC`, default 2: number of external reset request inputs.
- `EDGE_MODE`, default 2'b10: per-source trigger mode; 1 = falling edge of the filtered input, 0 = level-high.
- `SYNC_STAGES`, default 2 (minimum 2): synchroniser flops per source.
- `DEBOUNCE_CYCLES`, default 16 (minimum 1): stable cycles required before the filtered input changes.
- `STRETCH_CYCLES`, default 255 (minimum 1): cycles spent in ASSERT before release starts.
- `NUM_DOMAINS`, default 3: number of reset outputs.
- `STAGGER_CYCLES`, default 4 (minimum 1): cycles between successive domain releases.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-high (typically `!pll_locked`).
- `req_in`, input, NUM_SRC: raw asynchronous reset requests.
- `cause_clr`, input, 1: synchronous clear of `cause`.
- `rst_out`, output, NUM_DOMAINS: active-high domain resets.
- `busy`, output, 1: high whenever the block is not in RUN.
- `cause`, output, NUM_SRC+1: sticky cause flags. Bit `NUM_SRC` = power-on; bit i = source i.

## Operation
- Reset values:
  - `rst_out` = all ones; `busy` = 1.
  - `cause` = power-on bit only.
  - Synchroniser flops, filtered inputs and their delayed copies = 0.
  - State = ASSERT; counters = 0.
- Per-source path: synchroniser → debounce filter → trigger.
  - Debounce: a counter increments each cycle the synchronised value differs from the filtered value, and clears when they match. When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the filtered value takes the synchronised value and the counter clears.
  - Level-mode trigger = filtered value.
  - Edge-mode trigger = filtered value low while its one-cycle-delayed copy is high.
- State machine:
  - **ASSERT**: all `rst_out` high. The stretch counter counts 0..STRETCH_CYCLES-1, then the block moves to RELEASE. Any active trigger holds the counter at 0.
  - **RELEASE**: `rst_out[0]` clears on the entry edge. `rst_out[i]` clears STAGGER_CYCLES edges after `rst_out[i-1]`. On the edge that clears the last domain, the block moves to RUN.
  - **RUN**: all `rst_out` low; `busy` low.
- Any trigger in RELEASE or RUN: on the next edge all `rst_out` go high, counters clear, and the block returns to ASSERT.
- `cause[i]` sets on the edge the trigger for source i is registered. Set has priority over `cause_clr` in the same cycle. `cause_clr` clears every bit that is not being set.
- Simultaneous triggers: all corresponding cause bits set.
- Asserting `reset` at any point immediately forces the reset values, including in mid-RELEASE.

## Timing
- A `req_in` transition meeting setup before edge 1 reaches `rst_out` at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - With the default configuration this is edge 19.
  - Without debounce it is edge SYNC_STAGES+1.
- After `reset` deasserts (or after the last trigger is deasserted), `rst_out[i]` falls at edge STRETCH_CYCLES + i·STAGGER_CYCLES.
- `busy` falls on the same edge as `rst_out[NUM_DOMAINS-1]`.
- Counter widths: `$clog2(max+1)` of their terminal value. No wrap is possible, because every counter clears at its terminal value.
- All outputs are registered. No combinational path from `req_in` to any output.

## Configuration
- `RESET_SEQ_DEBOUNCE_EN`:
  - Defined: the debounce filter is instantiated per source, as described above.
  - Undefined: filtered value = synchroniser output, `DEBOUNCE_CYCLES` is ignored, and no debounce counters exist. Latency becomes SYNC_STAGES+1.

## Test plan
All scenarios use default parameters with `RESET_SEQ_DEBOUNCE_EN` defined.
- **Power-on**: `reset` high 5 cycles, then low, `req_in`=0 → `rst_out[0]` falls at edge 255, `rst_out[1]` at 259, `rst_out[2]` at 263. `busy` falls at 263. `cause`=3'b100.
- **Level source 0**: in RUN, `req_in[0]` high for 40 cycles → all `rst_out` high 19 edges after the rise; `cause[0]` set. `rst_out[0]` falls 255 edges after filtered `req_in[0]` drops.
- **Glitch rejection**: `req_in[0]` high for 10 cycles in RUN → no `rst_out` change; `cause` unchanged.
- **Edge source 1**: `req_in[1]` high for 30 cycles, then low → no reset on the rise; all `rst_out` high 19 edges after the fall; `cause[1]` set.
- **Retrigger in RELEASE**: falling edge on `req_in[1]` timed to register between the `rst_out[0]` and `rst_out[1]` releases → `rst_out[0]` high again the next edge, and the full 255-cycle stretch restarts.
- **Clear vs set**: `cause_clr` high in the same cycle the source-0 trigger registers, with `cause`=3'b110 → `cause`=3'b001.
